// File: rtl/shift_reg_controller_if.sv
// shift_reg_controller_if: transfer bundle; master drives start/din/dir/pause/sin, slave returns ready/busy/sout/sout_valid/done/q
interface shift_reg_controller_if #(parameter int N = 4);
  logic start, dir, pause, sin, ready, busy, sout, sout_valid, done;
  logic [N-1:0] din, q;
  modport master(output start, din, dir, pause, sin, input ready, busy, sout, sout_valid, done, q);
  modport slave(input start, din, dir, pause, sin, output ready, busy, sout, sout_valid, done, q);
endinterface

// File: rtl/shift_reg_controller.sv
// shift_reg_controller: full-duplex N-bit serial transceiver; clk, rst (sync, active-high), b (slave: start/din/dir/pause/sin in, ready/busy/sout/sout_valid/done/q out)
module shift_reg_controller #(parameter int N = 4) (
  input logic clk,
  input logic rst,
  shift_reg_controller_if.slave b
);
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [N-1:0] shreg, shreg_n;
  logic [CW-1:0] count;
  logic dir_l, shifting;
  assign shifting = state == SHIFT && !b.pause;
  assign shreg_n = dir_l ? {b.sin, shreg[N-1:1]} : {shreg[N-2:0], b.sin};
  assign b.ready = state == IDLE;
  assign b.busy = state != IDLE;
  assign b.done = state == DONE;
  assign b.sout_valid = shifting;
  assign b.sout = state == SHIFT && (dir_l ? shreg[0] : shreg[N-1]);
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (b.start ? SHIFT : IDLE)
            : state == SHIFT ? (shifting && count == LAST ? DONE : SHIFT)
            : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      count <= '0;
      dir_l <= 1'b0;
      b.q <= '0;
    end else if (state == IDLE && b.start) begin
      shreg <= b.din;
      dir_l <= b.dir;
      count <= '0;
    end else if (shifting) begin
      shreg <= shreg_n;
      count <= count == LAST ? '0 : count + CW'(1);
      if (count == LAST) b.q <= shreg_n;
    end
  end
endmodule

// File: tb/tb_shift_reg_controller.sv
// tb_shift_reg_controller: directed and randomized transfers checked against a positional bit model
module tb_shift_reg_controller;
  localparam int N = 4;
  logic clk = 0, rst = 1;
  int total = 0, bad = 0;
  shift_reg_controller_if #(.N(N)) b();
  shift_reg_controller #(.N(N)) dut(.clk(clk), .rst(rst), .b(b));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, o, e);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check_idle(input string tag, input logic [N-1:0] eq);
    chk({tag, "_ready"}, b.ready, 1);
    chk({tag, "_busy"}, b.busy, 0);
    chk({tag, "_done"}, b.done, 0);
    chk({tag, "_sout"}, b.sout, 0);
    chk({tag, "_svalid"}, b.sout_valid, 0);
    chk({tag, "_q"}, b.q, eq);
  endtask
  // sb[k] is the k-th serial bit presented on sin; first bit out is din MSB (dir=0) or LSB (dir=1)
  task automatic xfer(input logic [N-1:0] d, input logic dr, input logic [N-1:0] sb,
                      input int pause_at, input int pause_len, input bit hold);
    logic [N-1:0] eq;
    int k, pc;
    logic p;
    for (int i = 0; i < N; i++) eq[dr ? i : N-1-i] = sb[i];
    b.start = 1; b.din = d; b.dir = dr; b.pause = 0; b.sin = $urandom;
    #1 chk("accept_ready", b.ready, 1);
    step();
    b.start = hold; b.din = N'($urandom); b.dir = 1'($urandom);
    k = 0; pc = 0;
    while (k < N) begin
      p = k == pause_at && pc < pause_len;
      b.pause = p;
      b.sin = p ? 1'($urandom) : sb[k];
      #1;
      chk("shift_sout", b.sout, dr ? d[k] : d[N-1-k]);
      chk("shift_svalid", b.sout_valid, !p);
      chk("shift_busy", b.busy, 1);
      chk("shift_ready", b.ready, 0);
      chk("shift_done", b.done, 0);
      step();
      if (p) pc++; else k++;
    end
    b.pause = 1'($urandom);
    #1;
    chk("done_pulse", b.done, 1);
    chk("done_busy", b.busy, 1);
    chk("done_ready", b.ready, 0);
    chk("done_svalid", b.sout_valid, 0);
    chk("done_q", b.q, eq);
    step();
    b.pause = 0;
    chk("after_done", b.done, 0);
    chk("after_ready", b.ready, 1);
    chk("after_q", b.q, eq);
  endtask
  initial begin
    b.start = 1; b.din = 4'b1111; b.dir = 0; b.pause = 0; b.sin = 1;
    step();
    step();
    check_idle("reset", 0);
    rst = 0; b.start = 0;
    #1 check_idle("post_reset", 0);
    xfer(4'b1011, 0, 4'b0110, N, 0, 0);
    xfer(4'b1011, 1, 4'b1001, N, 0, 0);
    xfer(4'b1100, 0, 4'b0110, 2, 3, 0);
    xfer(4'b1001, 0, 4'b1010, N, 0, 1);
    xfer(4'b0110, 1, 4'b0011, N, 0, 1);
    b.start = 1; b.din = 4'b1110; b.dir = 0; b.pause = 0; b.sin = 1;
    step();
    b.start = 0;
    step();
    step();
    chk("mid_busy", b.busy, 1);
    rst = 1;
    step();
    rst = 0;
    check_idle("mid_reset", 0);
    step();
    check_idle("mid_reset2", 0);
    xfer(4'b0101, 0, 4'b1100, N, 0, 0);
    for (int t = 0; t < 30; t++)
      xfer(N'($urandom), 1'($urandom), N'($urandom), $urandom_range(0, N - 1),
           $urandom_range(0, 3), 1'($urandom));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
